// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: PC update, ALU and load writebacks share one write port,
// with an independent clear port; PC update has priority unless data writebacks are starving.
module regfile_write_arbiter #(
  parameter logic [3:0]  PC_REG       = 4'd15,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb0_valid,
  input  logic [3:0]  wb0_addr,
  input  logic [31:0] wb0_data,
  output logic        wb0_ready,
  input  logic        wb1_valid,
  input  logic [3:0]  wb1_addr,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  input  logic        pcu_valid,
  input  logic [31:0] pcu_data,
  output logic        pcu_ready,
  input  logic        clr_valid,
  input  logic [3:0]  clr_addr,
  output logic        clr_ready,
  output logic        rf_we,
  output logic [3:0]  rf_rc,
  output logic [31:0] rf_din,
  output logic        rf_ce,
  output logic [3:0]  rf_rd,
  output logic        rf_en
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          rr;
  logic [SW-1:0] stv;

  logic          data_any;
  logic          dsel;
  logic          ovr;
  logic          pgo;
  logic          dgo;
  logic          wr_go;
  logic          clr_go;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  // Grant decode; dsel=1 selects wb1 as the round-robin data winner.
  always_comb begin
    data_any  = wb0_valid | wb1_valid;
    dsel      = rr ? wb1_valid : ~wb0_valid;
    ovr       = (stv >= SW'(STARVE_LIMIT));
    pgo       = rst_n & pcu_valid & ~(ovr & data_any);
    dgo       = rst_n & data_any & ~pgo;
    wr_go     = pgo | dgo;
    waddr     = pgo ? PC_REG : (dsel ? wb1_addr : wb0_addr);
    wdata     = pgo ? pcu_data : (dsel ? wb1_data : wb0_data);
    clr_go    = rst_n & clr_valid & ~(wr_go & (clr_addr == waddr));
    wb0_ready = dgo & ~dsel;
    wb1_ready = dgo & dsel;
    pcu_ready = pgo;
    clr_ready = clr_go;
  end

  // Registered register-file strobes plus fairness state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we  <= 1'b0;
      rf_rc  <= '0;
      rf_din <= '0;
      rf_ce  <= 1'b0;
      rf_rd  <= '0;
      rf_en  <= 1'b0;
      rr     <= 1'b0;
      stv    <= '0;
    end else begin
      rf_we <= wr_go;
      rf_ce <= clr_go;
      rf_en <= wr_go | clr_go;
      if (wr_go) begin
        rf_rc  <= waddr;
        rf_din <= wdata;
      end
      if (clr_go) begin
        rf_rd <= clr_addr;
      end
      if (dgo) begin
        rr  <= ~rr;
        stv <= '0;
      end else if (pgo && data_any && (stv != {SW{1'b1}})) begin
        stv <= stv + SW'(1);
      end
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter PC_REG, default 4'd15, the register index written by the PC-update requester.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, the consecutive-loss count after which a data requester overrides PC priority (legal range 1..15).
REQ-003 Port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port RST_N  in  1  reset, asynchronous, active-low.
REQ-005 Ports WB0_VALID in 1, WB0_ADDR in 4, WB0_DATA in 32, WB0_READY out 1: ALU writeback requester.
REQ-006 Ports WB1_VALID in 1, WB1_ADDR in 4, WB1_DATA in 32, WB1_READY out 1: load writeback requester.
REQ-007 Ports PCU_VALID in 1, PCU_DATA in 32, PCU_READY out 1: PC-update requester; target register is always PC_REG.
REQ-008 Ports CLR_VALID in 1, CLR_ADDR in 4, CLR_READY out 1: register-clear requester.
REQ-009 Ports RF_WE out 1, RF_RC out 4, RF_DIN out 32: register file write enable, write select (RC), write data.
REQ-010 Ports RF_CE out 1, RF_RD out 4: register file clear enable, clear select (RD).
REQ-011 Port RF_EN  out 1  register file decoder enable, high when RF_WE or RF_CE is high.

Function
REQ-012 A transfer on any requester SHALL occur at a rising CLK edge where its VALID and READY are both 1; requesters hold VALID/ADDR/DATA stable until accepted.
REQ-013 READY outputs SHALL be combinational from current VALIDs, ADDRs and arbiter state; at most one of WB0_READY, WB1_READY, PCU_READY SHALL be 1 in any cycle.
REQ-014 Write-port priority SHALL be: PCU, then WB0/WB1 by round-robin; when the starvation override is active, the round-robin winner among WB0/WB1 SHALL beat PCU.
REQ-015 Round-robin pointer RR (reset 0 = WB0 preferred) SHALL toggle to the other data requester after each WB0 or WB1 transfer, and SHALL hold otherwise.
REQ-016 Starvation counter STV (4 bits, reset 0) SHALL increment, saturating at 15, each cycle PCU transfers while WB0_VALID or WB1_VALID is 1; SHALL clear on any WB0/WB1 transfer; override is active when STV >= STARVE_LIMIT.
REQ-017 The write transfer accepted at edge N SHALL drive RF_WE=1, RF_RC=address, RF_DIN=data for exactly the cycle following edge N (latency 1, registered); RF_WE=0 in cycles with no accepted write, RF_RC/RF_DIN then hold last value.
REQ-018 CLR_READY SHALL be 1 when CLR_VALID is 1 unless a write is being accepted in the same cycle to the same address (CLR_ADDR equals granted write address), in which case it SHALL be 0.
REQ-019 An accepted clear at edge N SHALL drive RF_CE=1, RF_RD=CLR_ADDR for the following cycle only; write and clear to different addresses SHALL proceed in the same cycle.
REQ-020 With no VALID asserted, all READYs SHALL be 0 and RF_WE, RF_CE, RF_EN SHALL be 0 after the next edge.
REQ-021 Back-to-back transfers SHALL be supported: one write and one clear per cycle sustained, no idle cycles inserted.

Reset
REQ-022 While RST_N=0, RF_WE, RF_CE, RF_EN SHALL be 0, RF_RC, RF_RD SHALL be 4'h0, RF_DIN SHALL be 32'h0, RR and STV SHALL be 0, all READYs SHALL be 0.
REQ-023 Assertion of RST_N mid-operation SHALL immediately drop any pending RF_WE/RF_CE pulse; no transfer SHALL be accepted at an edge where RST_N=0.
REQ-024 After RST_N deasserts, the first rising edge SHALL be able to accept a transfer.

Verification
REQ-025 WB0 only, ADDR=3, DATA=32'hDEADBEEF -> WB0_READY=1 same cycle; next cycle RF_WE=1, RF_RC=3, RF_DIN=32'hDEADBEEF, RF_EN=1; following cycle RF_WE=0.
REQ-026 WB0 (ADDR=1) and WB1 (ADDR=2) held valid 4 cycles from reset -> grants WB0,WB1,WB0,WB1; RF_RC sequence 1,2,1,2.
REQ-027 PCU (DATA=32'h100) and WB0 (ADDR=5) valid continuously, STARVE_LIMIT=4 -> PCU wins 4 edges, WB0 wins 5th, STV returns 0, PCU wins 6th; RF_RC=15 on PCU writes.
REQ-028 WB1 ADDR=7 and CLR ADDR=7 same cycle -> CLR_READY=0, write issued; next cycle CLR accepted, RF_CE=1, RF_RD=7; with CLR ADDR=6 instead both issue same cycle.
REQ-029 RST_N driven 0 in cycle where RF_WE=1 -> RF_WE, RF_EN fall immediately, RR=0, STV=0; after release, WB1-only request is granted on first edge.
